// File: rtl/mem_loader_pkg.sv
// Shared constants, state encoding and checksum helper for the program loader,
// reused by the CPU side and the testbench.
package mem_loader_pkg;

  localparam int MEM_DEPTH = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  // Counter/pointer is one bit wider than the address so it can hold N == MEM_DEPTH.
  localparam int CNT_W     = ADDR_W + 1;

  localparam logic [DATA_W-1:0] DEPTH_DATA = DATA_W'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]  LAST_PTR   = CNT_W'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_FILL = 3'd4,
    ST_RUN  = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  // 8-bit wrapping add used by the checksum accumulator.
  function automatic logic [DATA_W-1:0] add8(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream, memory-write and CPU-control signals of the program loader.
interface mem_loader_if;
  import mem_loader_pkg::*;

  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_run;
  logic              cpu_halted;
  logic              err;

  // Loader side.
  modport master (
    input  start, in_valid, in_data, cpu_halted,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, err
  );

  // Stream source / CPU side.
  modport slave (
    output start, in_valid, in_data, cpu_halted,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, err
  );

endinterface

// File: rtl/loader_cksum.sv
// 8-bit wrapping checksum accumulator with clear, add and a zero check of
// (acc + din) used to validate the trailing checksum byte.
module loader_cksum
  import mem_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  output logic              sum_zero
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  // Next accumulator value: clear wins over add.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = {DATA_W{1'b0}};
    end else if (add) begin
      acc_d = add8(acc_q, din);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= {DATA_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum_zero = (add8(acc_q, din) == {DATA_W{1'b0}});

endmodule

// File: rtl/mem_loader.sv
// Program loader: receives length/program/checksum byte stream, writes the
// CPU program memory, zero-fills the remainder and then releases the CPU.
module mem_loader (
  input logic          clock,
  input logic          reset_n,
  mem_loader_if.master bus
);
  import mem_loader_pkg::*;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  ptr_q, ptr_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              err_q, err_d;
  logic              acc_clr, acc_add, sum_zero;
  logic              xfer;

  assign xfer = bus.in_valid && in_ready_q;

  loader_cksum u_cksum (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (acc_clr),
    .add      (acc_add),
    .din      (bus.in_data),
    .sum_zero (sum_zero)
  );

  // Next-state, pointer and write-port computation; outputs derive from next state.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    acc_clr     = 1'b0;
    acc_add     = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (bus.start) begin
          state_d = ST_LEN;
          len_d   = {CNT_W{1'b0}};
          ptr_d   = {CNT_W{1'b0}};
          acc_clr = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          if ((bus.in_data == {DATA_W{1'b0}}) || (bus.in_data > DEPTH_DATA)) begin
            state_d = ST_ERR;
          end else begin
            len_d   = bus.in_data[CNT_W-1:0];
            acc_add = 1'b1;
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q[ADDR_W-1:0];
          mem_wdata_d = bus.in_data;
          acc_add     = 1'b1;
          ptr_d       = ptr_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (ptr_d == len_q) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CHK: begin
        if (xfer) begin
          if (!sum_zero) begin
            state_d = ST_ERR;
          end else if (len_q < DEPTH_CNT) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_CHK;
        end
      end
      ST_FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = ptr_q[ADDR_W-1:0];
        mem_wdata_d = {DATA_W{1'b0}};
        // Stop at the last address so the pointer never wraps.
        if (ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
        end else begin
          ptr_d   = ptr_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = ST_FILL;
        end
      end
      ST_RUN: begin
        if (bus.cpu_halted) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK);
    cpu_run_d  = (state_d == ST_RUN);
    err_d      = (state_d == ST_ERR);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      len_q       <= {CNT_W{1'b0}};
      ptr_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      cpu_run_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_run   = cpu_run_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed testbench for mem_loader: table of byte streams with expected
// write traces, plus hand sequences for backpressure, reset abort and halt.
module tb_mem_loader;
  import mem_loader_pkg::*;

  logic clock;
  logic reset_n;

  mem_loader_if bus_if();

  mem_loader dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [DATA_W-1:0] wd[$];

  // Write monitor: log every write strobe seen away from the active edge.
  always @(negedge clock) begin
    if (bus_if.mem_we) begin
      wa.push_back(bus_if.mem_addr);
      wd.push_back(bus_if.mem_wdata);
    end
  end

  typedef struct packed {
    logic [15:0] off;
    logic [7:0]  cnt;
    logic [7:0]  n_data;
    logic [7:0]  n_fill;
    logic        exp_err;
    logic        exp_run;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] pool[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock) bus_if.start = 1'b1;
    @(negedge clock) bus_if.start = 1'b0;
  endtask

  task automatic halt_cpu();
    @(negedge clock) bus_if.cpu_halted = 1'b1;
    @(negedge clock) bus_if.cpu_halted = 1'b0;
  endtask

  // Drive one byte per cycle, then count negedges until run or err appears.
  task automatic send_stream(input int off, input int cnt, output int lat);
    for (int i = 0; i < cnt; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = pool[off + i];
      @(negedge clock);
    end
    bus_if.in_valid = 1'b0;
    lat = 1;
    while (!(bus_if.cpu_run || bus_if.err) && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic push_good();
    pool.push_back(8'h03); pool.push_back(8'hE8); pool.push_back(8'h01);
    pool.push_back(8'h02); pool.push_back(8'h12);
  endtask

  initial begin
    int lat;
    int off;
    logic [7:0] ed;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int off;
    int good_off;
    logic [7:0] ed;

    // Vector table: streams and expected outcomes.
    vecs[0] = '{off: 16'(pool.size()), cnt: 8'd5, n_data: 8'd3, n_fill: 8'd0, exp_err: 1'b1, exp_run: 1'b0};
    pool.push_back(8'h03); pool.push_back(8'hE8); pool.push_back(8'h01);
    pool.push_back(8'h02); pool.push_back(8'h13);
    good_off = pool.size();
    vecs[1] = '{off: 16'(pool.size()), cnt: 8'd5, n_data: 8'd3, n_fill: 8'd29, exp_err: 1'b0, exp_run: 1'b1};
    push_good();
    vecs[2] = '{off: 16'(pool.size()), cnt: 8'd1, n_data: 8'd0, n_fill: 8'd0, exp_err: 1'b1, exp_run: 1'b0};
    pool.push_back(8'h00);
    vecs[3] = '{off: 16'(pool.size()), cnt: 8'd1, n_data: 8'd0, n_fill: 8'd0, exp_err: 1'b1, exp_run: 1'b0};
    pool.push_back(8'h21);
    vecs[4] = '{off: 16'(pool.size()), cnt: 8'd34, n_data: 8'd32, n_fill: 8'd0, exp_err: 1'b0, exp_run: 1'b1};
    pool.push_back(8'h20);
    for (int i = 0; i < 32; i++) pool.push_back(8'(i));
    pool.push_back(8'hF0);
    vecs[5] = '{off: 16'(pool.size()), cnt: 8'd5, n_data: 8'd3, n_fill: 8'd29, exp_err: 1'b0, exp_run: 1'b1};
    push_good();

    // Reset state.
    reset_n           = 1'b0;
    bus_if.start      = 1'b0;
    bus_if.in_valid   = 1'b0;
    bus_if.in_data    = 8'h00;
    bus_if.cpu_halted = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    chk("rst_mem_we", 32'(bus_if.mem_we), 32'd0);
    chk("rst_cpu_run", 32'(bus_if.cpu_run), 32'd0);
    chk("rst_err", 32'(bus_if.err), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_in_ready", 32'(bus_if.in_ready), 32'd0);

    // Table-driven loads.
    for (int v = 0; v < 6; v++) begin
      if (bus_if.cpu_run) halt_cpu();
      wa.delete();
      wd.delete();
      pulse_start();
      chk($sformatf("v%0d_ready_after_start", v), 32'(bus_if.in_ready), 32'd1);
      chk($sformatf("v%0d_err_cleared", v), 32'(bus_if.err), 32'd0);
      off = int'(vecs[v].off);
      send_stream(off, int'(vecs[v].cnt), lat);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(1 + int'(vecs[v].n_fill)));
      chk($sformatf("v%0d_err", v), 32'(bus_if.err), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_cpu_run", v), 32'(bus_if.cpu_run), 32'(vecs[v].exp_run));
      chk($sformatf("v%0d_in_ready_end", v), 32'(bus_if.in_ready), 32'd0);
      repeat (3) @(negedge clock);
      #1;
      chk($sformatf("v%0d_write_count", v), 32'(wa.size()),
          32'(int'(vecs[v].n_data) + int'(vecs[v].n_fill)));
      for (int k = 0; k < wa.size(); k++) begin
        ed = (k < int'(vecs[v].n_data)) ? pool[off + 1 + k] : 8'h00;
        chk($sformatf("v%0d_w%0d_addr", v, k), 32'(wa[k]), 32'(k));
        chk($sformatf("v%0d_w%0d_data", v, k), 32'(wd[k]), 32'(ed));
      end
    end

    // Backpressure during DATA, then reset abort after the 2nd data byte.
    halt_cpu();
    chk("halt_run_low", 32'(bus_if.cpu_run), 32'd0);
    pulse_start();
    bus_if.in_valid = 1'b1; bus_if.in_data = 8'h03;
    @(negedge clock);
    chk("bp_len_no_write", 32'(bus_if.mem_we), 32'd0);
    bus_if.in_valid = 1'b1; bus_if.in_data = 8'hE8;
    @(negedge clock);
    chk("bp_w0_we", 32'(bus_if.mem_we), 32'd1);
    chk("bp_w0_addr", 32'(bus_if.mem_addr), 32'd0);
    chk("bp_w0_data", 32'(bus_if.mem_wdata), 32'hE8);
    bus_if.in_valid = 1'b0; bus_if.in_data = 8'h5A;
    @(negedge clock);
    chk("bp_gap_no_write", 32'(bus_if.mem_we), 32'd0);
    bus_if.in_valid = 1'b1; bus_if.in_data = 8'h01;
    @(negedge clock);
    chk("bp_w1_we", 32'(bus_if.mem_we), 32'd1);
    chk("bp_w1_addr", 32'(bus_if.mem_addr), 32'd1);
    chk("bp_w1_data", 32'(bus_if.mem_wdata), 32'h01);
    bus_if.in_valid = 1'b0; bus_if.in_data = 8'h55;
    @(negedge clock);
    chk("bp_gap2_no_write", 32'(bus_if.mem_we), 32'd0);
    chk("bp_still_ready", 32'(bus_if.in_ready), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus_if.in_ready), 32'd0);
    chk("abort_mem_addr", 32'(bus_if.mem_addr), 32'd0);
    chk("abort_mem_wdata", 32'(bus_if.mem_wdata), 32'd0);
    chk("abort_cpu_run", 32'(bus_if.cpu_run), 32'd0);
    chk("abort_err", 32'(bus_if.err), 32'd0);
    @(negedge clock);
    wa.delete();
    wd.delete();
    reset_n = 1'b1;
    bus_if.in_valid = 1'b1; bus_if.in_data = 8'h77;
    repeat (3) @(negedge clock);
    #1;
    chk("abort_no_writes", 32'(wa.size()), 32'd0);
    chk("abort_idle_not_ready", 32'(bus_if.in_ready), 32'd0);
    bus_if.in_valid = 1'b0;
    pulse_start();
    chk("abort_restart_ready", 32'(bus_if.in_ready), 32'd1);
    send_stream(good_off, 5, lat);
    chk("abort_reload_latency", 32'(lat), 32'd30);
    chk("abort_reload_run", 32'(bus_if.cpu_run), 32'd1);

    // Halt handshake; start during RUN and halted outside RUN are ignored.
    @(negedge clock) bus_if.start = 1'b1;
    @(negedge clock) bus_if.start = 1'b0;
    chk("run_start_ignored_run", 32'(bus_if.cpu_run), 32'd1);
    chk("run_start_ignored_ready", 32'(bus_if.in_ready), 32'd0);
    repeat (2) @(negedge clock);
    chk("run_held", 32'(bus_if.cpu_run), 32'd1);
    bus_if.cpu_halted = 1'b1;
    @(negedge clock) bus_if.cpu_halted = 1'b0;
    chk("halt_cpu_run_low", 32'(bus_if.cpu_run), 32'd0);
    chk("halt_in_ready", 32'(bus_if.in_ready), 32'd0);
    chk("halt_err", 32'(bus_if.err), 32'd0);
    bus_if.cpu_halted = 1'b1;
    repeat (2) @(negedge clock);
    bus_if.cpu_halted = 1'b0;
    chk("idle_halted_ignored", 32'(bus_if.cpu_run), 32'd0);
    pulse_start();
    chk("idle_after_halt_start", 32'(bus_if.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameters: MEM_DEPTH, 32, memory words; ADDR_W, 5, address width; DATA_W, 8, word width.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin a load; honoured only in IDLE or ERR.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  DATA_W  byte-stream data.
REQ-007 in_ready  output  1  loader accepts a byte; a transfer occurs on in_valid && in_ready.
REQ-008 mem_we  output  1  write strobe to the CPU's 32x8 program memory.
REQ-009 mem_addr  output  ADDR_W  write address.
REQ-010 mem_wdata  output  DATA_W  write data.
REQ-011 cpu_run  output  1  CPU enable; the CPU fetches from PC=0 while high.
REQ-012 cpu_halted  input  1  CPU has executed HLT; sampled only in RUN.
REQ-013 err  output  1  load failed; held until the next accepted start.

Function
REQ-014 Stream format: length byte N, then N program bytes, then checksum byte C.
REQ-015 Checksum rule: (N + sum of program bytes + C) mod 256 == 0, accumulated in 8 bits with wrap.
REQ-016 States: IDLE, LEN, DATA, CHK, FILL, RUN, ERR.
REQ-017 IDLE -> LEN on start; also clears the byte counter, address pointer and accumulator.
REQ-018 in_ready is 1 in LEN, DATA and CHK, and 0 in all other states.
REQ-019 LEN, transfer with N==0 or N>MEM_DEPTH -> ERR; otherwise store N, acc=N, -> DATA.
REQ-020 DATA, each transfer -> one write of the byte at the address pointer (0,1,...,N-1).
REQ-021 DATA, each transfer also adds the byte to acc; after the N-th transfer -> CHK.
REQ-022 CHK, transfer with (acc+C)[7:0]!=0 -> ERR; otherwise -> FILL if N<MEM_DEPTH, else -> RUN.
REQ-023 FILL writes 0x00 to addresses N..MEM_DEPTH-1, one per cycle, and accepts no input; after address MEM_DEPTH-1 -> RUN.
REQ-024 Write latency: mem_we/mem_addr/mem_wdata are registered and assert exactly one cycle after the accepting edge (DATA) or FILL step; mem_we is high for one cycle per write.
REQ-025 No memory write occurs in LEN, CHK, RUN, ERR or IDLE.
REQ-026 RUN, cpu_run=1 from the first RUN cycle; cpu_halted=1 -> IDLE, with cpu_run low on the next cycle.
REQ-027 ERR, err=1 and cpu_run=0; start -> LEN with err cleared in the same edge.
REQ-028 start in LEN, DATA, CHK, FILL or RUN is ignored.
REQ-029 cpu_halted outside RUN is ignored.
REQ-030 in_valid gaps stall the FSM with no state change and no write.
REQ-031 The address pointer never wraps; the N==MEM_DEPTH path writes address 31 last and skips FILL.

Reset
REQ-032 reset_n low forces IDLE asynchronously.
REQ-033 Reset clears to 0: in_ready, mem_we, mem_addr, mem_wdata, cpu_run, err, counter and acc.
REQ-034 Reset mid-load or mid-RUN aborts immediately; no partial write is issued after reset deasserts.

Structure
REQ-035 A shared package holds MEM_DEPTH, ADDR_W, DATA_W and the state encoding, for reuse by the CPU and the bench.
REQ-036 The single natural sub-module is loader_cksum: an 8-bit wrapping accumulator with clear/add/zero-check.

Verification
REQ-037 Good load: stream 03,E8,01,02,12 -> writes 0:E8, 1:01, 2:02; then 0x00 to addresses 3..31 over 29 cycles; then cpu_run=1, err=0.
REQ-038 Bad checksum: stream 03,E8,01,02,13 -> three writes, no FILL, err=1, cpu_run=0; a subsequent start plus a good stream recovers.
REQ-039 Bad length: N=00 and N=21h (33) -> each gives ERR right after the length byte, with zero writes.
REQ-040 Full load: N=20h (32) with a valid checksum -> 32 writes, no FILL cycles; the RUN entry is one cycle after the CHK transfer.
REQ-041 Backpressure and abort:
- in_valid toggling 1/0 during DATA -> writes appear only on transfer edges.
- reset_n low after the 2nd data byte -> IDLE, all outputs 0, no further writes.
REQ-042 Halt handshake: in RUN, cpu_halted=1 for one cycle -> cpu_run=0 on the next cycle and state IDLE; start pulsed during RUN has no effect.
